// File: rtl/exc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exc_ctrl_if : decode-side bus between the pipeline and exc_ctrl      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface exc_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  instr_valid;
    logic [4:0]            op;
    logic                  illegal_op;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  flush;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [DATA_WIDTH-1:0] epc;
    logic                  in_handler;
    logic                  double_fault;
    logic [1:0]            cause;

    modport master (
        output instr_valid, op, illegal_op, pc_next,
        input  flush, redirect, redirect_pc, epc, in_handler, double_fault, cause
    );

    modport slave (
        input  instr_valid, op, illegal_op, pc_next,
        output flush, redirect, redirect_pc, epc, in_handler, double_fault, cause
    );
endinterface
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exc_ctrl : exception sequencer (EPC capture, flush, vector, RTI).    |
// | Optional macro EXC_CAUSE_EN builds the cause register. Revision: 1.0 |
// +----------------------------------------------------------------------+
module exc_ctrl #(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 16'h0002,
    parameter int                    FLUSH_CYCLES = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    exc_ctrl_if.slave      bus
);

    localparam logic [4:0] OP_SIIC    = 5'b00010;
    localparam logic [4:0] OP_RTI     = 5'b00011;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        REDIR   = 3'd2,
        HANDLER = 3'd3,
        DFAULT  = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] epc, epc_nxt;
    logic [DATA_WIDTH-1:0] redirect_pc, redirect_pc_nxt;
    logic                  flush, flush_nxt;
    logic                  redirect, redirect_nxt;
    logic                  in_handler, in_handler_nxt;
    logic                  double_fault, double_fault_nxt;
    logic                  trigger, rti, capture, rti_fire;

    assign trigger = bus.instr_valid & (bus.illegal_op | (bus.op == OP_SIIC));
    assign rti     = bus.instr_valid & ~bus.illegal_op & (bus.op == OP_RTI);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        epc_nxt         = epc;
        redirect_pc_nxt = redirect_pc;
        capture         = 1'b0;
        rti_fire        = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                    epc_nxt   = bus.pc_next;
                    capture   = 1'b1;
                end else if (rti) begin
                    rti_fire        = 1'b1;
                    redirect_pc_nxt = epc;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = REDIR;
                end
            end
            REDIR: begin
                state_nxt = HANDLER;
            end
            HANDLER: begin
                // A fault inside the handler is fatal; EPC keeps the first return address.
                if (trigger) begin
                    state_nxt = DFAULT;
                end else if (rti) begin
                    state_nxt       = IDLE;
                    rti_fire        = 1'b1;
                    redirect_pc_nxt = epc;
                end
            end
            DFAULT: begin
                state_nxt = DFAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == REDIR) begin
            redirect_pc_nxt = EXC_VECTOR;
        end
        flush_nxt        = (state_nxt == FLUSH) || (state_nxt == REDIR) ||
                           (state_nxt == DFAULT) || rti_fire;
        redirect_nxt     = (state_nxt == REDIR) || rti_fire;
        in_handler_nxt   = (state_nxt == HANDLER);
        double_fault_nxt = (state_nxt == DFAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            epc          <= '0;
            redirect_pc  <= '0;
            flush        <= 1'b0;
            redirect     <= 1'b0;
            in_handler   <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            epc          <= epc_nxt;
            redirect_pc  <= redirect_pc_nxt;
            flush        <= flush_nxt;
            redirect     <= redirect_nxt;
            in_handler   <= in_handler_nxt;
            double_fault <= double_fault_nxt;
        end
    end

`ifdef EXC_CAUSE_EN
    logic [1:0] cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause <= 2'd0;
        end else if (capture) begin
            cause <= bus.illegal_op ? 2'd1 : 2'd2;
        end else if (rti_fire) begin
            cause <= 2'd0;
        end
    end

    assign bus.cause = cause;
`else
    assign bus.cause = 2'b00;
`endif

    assign bus.flush        = flush;
    assign bus.redirect     = redirect;
    assign bus.redirect_pc  = redirect_pc;
    assign bus.epc          = epc;
    assign bus.in_handler   = in_handler;
    assign bus.double_fault = double_fault;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exc_ctrl : directed bench for exc_ctrl (FLUSH_CYCLES 2 and 4).    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_exc_ctrl;

    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;
`ifdef EXC_CAUSE_EN
    localparam logic [1:0] EXP_ILL  = 2'd1;
    localparam logic [1:0] EXP_SIIC = 2'd2;
`else
    localparam logic [1:0] EXP_ILL  = 2'd0;
    localparam logic [1:0] EXP_SIIC = 2'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n4 = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    exc_ctrl_if #(.DATA_WIDTH(16)) bus  ();
    exc_ctrl_if #(.DATA_WIDTH(16)) bus4 ();

    exc_ctrl #(.DATA_WIDTH(16), .EXC_VECTOR(16'h0002), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    exc_ctrl #(.DATA_WIDTH(16), .EXC_VECTOR(16'h0002), .FLUSH_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .bus(bus4.slave));

    // status nibble = {flush, redirect, in_handler, double_fault}
    wire logic [3:0] st  = {bus.flush,  bus.redirect,  bus.in_handler,  bus.double_fault};
    wire logic [3:0] st4 = {bus4.flush, bus4.redirect, bus4.in_handler, bus4.double_fault};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic ill, input logic [15:0] pc);
        bus.instr_valid = v;
        bus.op          = o;
        bus.illegal_op  = ill;
        bus.pc_next     = pc;
    endtask

    task automatic drive4(input logic v, input logic [4:0] o, input logic ill, input logic [15:0] pc);
        bus4.instr_valid = v;
        bus4.op          = o;
        bus4.illegal_op  = ill;
        bus4.pc_next     = pc;
    endtask

    task automatic test_reset();
        drive(0, OP_ADD, 0, 16'h0);
        drive4(0, OP_ADD, 0, 16'h0);
        rst_n = 1'b0; rst_n4 = 1'b0;
        #12;
        vectors++;
        if ({st, bus.epc, bus.redirect_pc, bus.cause} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_dut got st=%b epc=%h rpc=%h cause=%0d want all zero",
                     st, bus.epc, bus.redirect_pc, bus.cause);
        end
        vectors++;
        if ({st4, bus4.epc, bus4.redirect_pc, bus4.cause} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_dut4 got st=%b epc=%h rpc=%h cause=%0d want all zero",
                     st4, bus4.epc, bus4.redirect_pc, bus4.cause);
        end
        #10 rst_n = 1'b1; rst_n4 = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        logic [3:0] exp;
        drive(1, OP_ADD, 1, 16'h0040);
        tick();
        drive(0, OP_ADD, 0, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            exp = (c <= 2) ? 4'b1000 : (c == 3) ? 4'b1100 : 4'b0010;
            vectors++;
            if (st !== exp) begin
                miscompares++;
                $display("FAIL illegal_status cyc+%0d got %b want %b", c, st, exp);
            end
            if (c == 3) begin
                vectors++;
                if (bus.redirect_pc !== 16'h0002) begin
                    miscompares++;
                    $display("FAIL illegal_vector got %h want 0002", bus.redirect_pc);
                end
            end
            if (c < 4) tick();
        end
        vectors++;
        if (bus.epc !== 16'h0040 || bus.cause !== EXP_ILL) begin
            miscompares++;
            $display("FAIL illegal_epc_cause got epc=%h cause=%0d want 0040/%0d", bus.epc, bus.cause, EXP_ILL);
        end
    endtask

    task automatic test_rti(input logic [15:0] exp_pc);
        drive(1, OP_RTI, 0, 16'h0ABC);
        tick();
        drive(0, OP_ADD, 0, 16'h0);
        vectors++;
        if (st !== 4'b1100 || bus.redirect_pc !== exp_pc || bus.cause !== 2'd0) begin
            miscompares++;
            $display("FAIL rti_redirect got st=%b rpc=%h cause=%0d want 1100/%h/0",
                     st, bus.redirect_pc, bus.cause, exp_pc);
        end
        tick();
        vectors++;
        if (st !== 4'b0000 || bus.redirect_pc !== exp_pc) begin
            miscompares++;
            $display("FAIL rti_after got st=%b rpc=%h want 0000/%h", st, bus.redirect_pc, exp_pc);
        end
    endtask

    task automatic test_flush_window();
        logic [3:0] exp;
        drive(1, OP_SIIC, 0, 16'h0100);
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) drive(1, OP_SIIC, 0, 16'h0200);
            else if (c == 2) drive(1, OP_SIIC, 0, 16'h0300);
            else if (c == 3) drive(1, OP_ADD, 1, 16'h0400);
            else drive(0, OP_ADD, 0, 16'h0);
            exp = (c <= 2) ? 4'b1000 : (c == 3) ? 4'b1100 : 4'b0010;
            vectors++;
            if (st !== exp || bus.epc !== 16'h0100) begin
                miscompares++;
                $display("FAIL flush_window cyc+%0d got st=%b epc=%h want %b/0100", c, st, bus.epc, exp);
            end
            if (c < 5) tick();
        end
        vectors++;
        if (bus.cause !== EXP_SIIC) begin
            miscompares++;
            $display("FAIL siic_cause got %0d want %0d", bus.cause, EXP_SIIC);
        end
    endtask

    task automatic test_valid_low();
        drive(0, OP_SIIC, 1, 16'h0777);
        tick();
        tick();
        drive(0, OP_ADD, 0, 16'h0);
        vectors++;
        if (st !== 4'b0000 || bus.epc !== 16'h0100) begin
            miscompares++;
            $display("FAIL valid_low got st=%b epc=%h want 0000/0100", st, bus.epc);
        end
    endtask

    task automatic test_double_fault();
        drive(1, OP_ADD, 1, 16'h0500);
        tick();
        drive(0, OP_ADD, 0, 16'h0);
        repeat (3) tick();
        vectors++;
        if (st !== 4'b0010) begin
            miscompares++;
            $display("FAIL dfault_entry got %b want 0010", st);
        end
        drive(1, OP_SIIC, 0, 16'h0600);
        tick();
        for (int c = 0; c < 22; c++) begin
            if (c == 5) drive(1, OP_RTI, 0, 16'h0);
            else drive(0, OP_ADD, 0, 16'h0);
            vectors++;
            if (st !== 4'b1001 || bus.epc !== 16'h0500 || bus.cause !== EXP_ILL) begin
                miscompares++;
                $display("FAIL dfault_hold c%0d got st=%b epc=%h cause=%0d want 1001/0500/%0d",
                         c, st, bus.epc, bus.cause, EXP_ILL);
            end
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({st, bus.epc, bus.redirect_pc, bus.cause} !== 38'd0) begin
            miscompares++;
            $display("FAIL dfault_reset got st=%b epc=%h rpc=%h want zero", st, bus.epc, bus.redirect_pc);
        end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        drive4(1, OP_SIIC, 0, 16'h0700);
        tick();
        drive4(0, OP_ADD, 0, 16'h0);
        tick();
        #2 rst_n4 = 1'b0;
        #1;
        vectors++;
        if ({st4, bus4.epc, bus4.redirect_pc, bus4.cause} !== 38'd0) begin
            miscompares++;
            $display("FAIL midreset_async got st=%b epc=%h rpc=%h want zero", st4, bus4.epc, bus4.redirect_pc);
        end
        tick();
        #3 rst_n4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (st4 !== 4'b0000) begin
                miscompares++;
                $display("FAIL midreset_quiet c%0d got %b want 0000", c, st4);
            end
        end
        drive4(1, OP_ADD, 1, 16'h0040);
        tick();
        drive4(0, OP_ADD, 0, 16'h0);
        for (int c = 1; c <= 6; c++) begin
            exp = (c <= 4) ? 4'b1000 : (c == 5) ? 4'b1100 : 4'b0010;
            vectors++;
            if (st4 !== exp) begin
                miscompares++;
                $display("FAIL f4_status cyc+%0d got %b want %b", c, st4, exp);
            end
            if (c == 5) begin
                vectors++;
                if (bus4.redirect_pc !== 16'h0002) begin
                    miscompares++;
                    $display("FAIL f4_vector got %h want 0002", bus4.redirect_pc);
                end
            end
            if (c < 6) tick();
        end
        vectors++;
        if (bus4.epc !== 16'h0040 || bus4.cause !== EXP_ILL) begin
            miscompares++;
            $display("FAIL f4_epc_cause got epc=%h cause=%0d want 0040/%0d", bus4.epc, bus4.cause, EXP_ILL);
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_rti(16'h0040);
        test_flush_window();
        test_rti(16'h0100);
        test_rti(16'h0100);
        test_valid_low();
        test_double_fault();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
